// File: rtl/charge_controller.sv
// Charge-entry controller for the A/C prepaid power meter: keypad entry of a charge amount,
// commit into the power register, and a small circular store of past charges for display.
module charge_controller #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_POWER = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       on_off,
    input  logic       charge_en,
    input  logic       record_en,
    input  logic [9:0] power_in,
    output logic [9:0] power_out,
    output logic       power_load,
    output logic [9:0] add_show,
    output logic [9:0] power_show,
    output logic [2:0] rec_count,
    output logic [1:0] cur_idx
);

    localparam logic [13:0] MAX_C    = 14'(MAX_POWER);
    localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0]  IDX_MASK = 2'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_COMMIT,
        S_QUERY
    } state_e;

    state_e      state_q, state_d, mode;
    logic [9:0]  add_q, add_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rec_count_q, rec_count_d;
    logic [1:0]  cur_idx_q, cur_idx_d;
    logic [9:0]  power_out_q, power_out_d;
    logic        power_load_q, power_load_d;
    logic [9:0]  add_show_q, add_show_d;
    logic [9:0]  power_show_q, power_show_d;
    logic        rec_we;
    logic [9:0]  rec_add_q [DEPTH];
    logic [9:0]  rec_pwr_q [DEPTH];

    logic        key_ok;
    logic [13:0] limit;
    logic [13:0] cand;

    always_comb begin
        mode = S_IDLE;
        if (!on_off && charge_en) begin
            mode = record_en ? S_QUERY : S_ENTRY;
        end
        // A key is only honoured when the mode switches agree with the current state.
        key_ok = key_valid && (state_q == mode);
        limit  = (14'(power_in) > MAX_C) ? '0 : MAX_C - 14'(power_in);
        cand   = 14'(add_q) * 14'd10 + 14'(key_code);
    end

    always_comb begin
        state_d      = mode;
        add_d        = add_q;
        wr_ptr_d     = wr_ptr_q;
        rec_count_d  = rec_count_q;
        cur_idx_d    = cur_idx_q;
        power_out_d  = power_out_q;
        power_load_d = 1'b0;
        rec_we       = 1'b0;

        case (state_q)
            S_ENTRY: begin
                if (key_ok) begin
                    if (key_code <= 4'd9) begin
                        add_d = (cand > limit) ? limit[9:0] : cand[9:0];
                    end else if (key_code == 4'hF) begin
                        add_d = '0;
                    end else if (key_code == 4'hE && add_q != '0) begin
                        state_d = S_COMMIT;
                    end
                end
                if (mode != S_ENTRY) begin
                    add_d = '0;
                end
            end
            S_COMMIT: begin
                power_out_d  = power_in + add_q;
                power_load_d = 1'b1;
                rec_we       = 1'b1;
                wr_ptr_d     = (wr_ptr_q + 2'd1) & IDX_MASK;
                rec_count_d  = (rec_count_q == DEPTH_C) ? rec_count_q : rec_count_q + 3'd1;
                add_d        = '0;
            end
            S_QUERY: begin
                if (key_ok) begin
                    if (key_code <= 4'd9) begin
                        if (rec_count_q == '0) begin
                            cur_idx_d = '0;
                        end else if (key_code < {1'b0, rec_count_q}) begin
                            cur_idx_d = key_code[1:0];
                        end else begin
                            cur_idx_d = 2'(rec_count_q - 3'd1);
                        end
                    end else if (key_code == 4'hF) begin
                        cur_idx_d = '0;
                    end else if (key_code == 4'hE) begin
                        cur_idx_d = (rec_count_q == '0) ? 2'd0 : ((wr_ptr_q - 2'd1) & IDX_MASK);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        add_show_d   = '0;
        power_show_d = '0;
        case (state_q)
            S_ENTRY, S_COMMIT: begin
                add_show_d   = add_q;
                power_show_d = power_in;
            end
            S_QUERY: begin
                add_show_d   = rec_add_q[cur_idx_q];
                power_show_d = rec_pwr_q[cur_idx_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            add_q        <= '0;
            wr_ptr_q     <= '0;
            rec_count_q  <= '0;
            cur_idx_q    <= '0;
            power_out_q  <= '0;
            power_load_q <= 1'b0;
            add_show_q   <= '0;
            power_show_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rec_add_q[i] <= '0;
                rec_pwr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            add_q        <= add_d;
            wr_ptr_q     <= wr_ptr_d;
            rec_count_q  <= rec_count_d;
            cur_idx_q    <= cur_idx_d;
            power_out_q  <= power_out_d;
            power_load_q <= power_load_d;
            add_show_q   <= add_show_d;
            power_show_q <= power_show_d;
            if (rec_we) begin
                rec_add_q[wr_ptr_q] <= add_q;
                rec_pwr_q[wr_ptr_q] <= power_out_d;
            end
        end
    end

    assign power_out  = power_out_q;
    assign power_load = power_load_q;
    assign add_show   = add_show_q;
    assign power_show = power_show_q;
    assign rec_count  = rec_count_q;
    assign cur_idx    = cur_idx_q;

endmodule

// File: tb/tb_charge_controller.sv
// Scoreboard bench for charge_controller: stimulus queues timed expectations and load values,
// a negedge monitor pops and compares them against the registered outputs.
module tb_charge_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic       on_off = 1'b0;
    logic       charge_en = 1'b0;
    logic       record_en = 1'b0;
    logic [9:0] power_in = '0;
    logic [9:0] power_out;
    logic       power_load;
    logic [9:0] add_show;
    logic [9:0] power_show;
    logic [2:0] rec_count;
    logic [1:0] cur_idx;

    charge_controller #(.DEPTH(4), .MAX_POWER(999)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .on_off     (on_off),
        .charge_en  (charge_en),
        .record_en  (record_en),
        .power_in   (power_in),
        .power_out  (power_out),
        .power_load (power_load),
        .add_show   (add_show),
        .power_show (power_show),
        .rec_count  (rec_count),
        .cur_idx    (cur_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {F_ADD, F_PWR, F_CNT, F_IDX, F_POUT, F_LOAD} field_e;
    typedef struct {
        int     tag;
        field_e fld;
        int     val;
        string  name;
    } exp_t;

    exp_t sb[$];
    int   load_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int actual(field_e f);
        case (f)
            F_ADD:   return int'(add_show);
            F_PWR:   return int'(power_show);
            F_CNT:   return int'(rec_count);
            F_IDX:   return int'(cur_idx);
            F_POUT:  return int'(power_out);
            default: return int'(power_load);
        endcase
    endfunction

    always @(negedge clk) begin
        int e;
        int a;
        if (power_load) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: got power_out=%0d expected no power_load", power_out);
            end else begin
                e = load_q.pop_front();
                if (int'(power_out) != e) begin
                    errors++;
                    $display("FAIL load_value: got power_out=%0d expected %0d", power_out, e);
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag == cyc) begin
                a = actual(sb[i].fld);
                checks++;
                if (a != sb[i].val) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d", sb[i].name, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int k, input string nm, input field_e f, input int v);
        exp_t x;
        x.tag  = cyc + k;
        x.fld  = f;
        x.val  = v;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] d, input int pout);
        key(d);
        key(4'hE);
        load_q.push_back(pout);
        step(1);
    endtask

    initial begin
        // Reset state
        step(2);
        expect_at(1, "rst_add_show", F_ADD, 0);
        expect_at(1, "rst_power_show", F_PWR, 0);
        expect_at(1, "rst_rec_count", F_CNT, 0);
        expect_at(1, "rst_cur_idx", F_IDX, 0);
        expect_at(1, "rst_power_out", F_POUT, 0);
        expect_at(1, "rst_power_load", F_LOAD, 0);
        step(1);
        rst = 1'b1;

        // 100 + 50 commit, then view record 0, then idle blanking
        power_in  = 10'd100;
        charge_en = 1'b1;
        step(1);
        key(4'd5);
        expect_at(1, "t1_add5", F_ADD, 5);
        key(4'd0);
        expect_at(1, "t1_add50", F_ADD, 50);
        expect_at(1, "t1_power_show", F_PWR, 100);
        key(4'hE);
        load_q.push_back(150);
        expect_at(1, "t1_rec_count", F_CNT, 1);
        expect_at(2, "t1_add_cleared", F_ADD, 0);
        expect_at(2, "t1_load_one_cycle", F_LOAD, 0);
        step(1);
        record_en = 1'b1;
        expect_at(2, "t1_rec0_add", F_ADD, 50);
        expect_at(2, "t1_rec0_pwr", F_PWR, 150);
        step(2);
        charge_en = 1'b0;
        record_en = 1'b0;
        expect_at(2, "idle_add_show", F_ADD, 0);
        expect_at(2, "idle_power_show", F_PWR, 0);
        step(2);

        // Clamp near the ceiling; a key on the entering edge is dropped
        power_in  = 10'd990;
        charge_en = 1'b1;
        key(4'd7);
        key(4'd4);
        expect_at(1, "t2_add4", F_ADD, 4);
        key(4'd2);
        expect_at(1, "t2_clamp9", F_ADD, 9);
        expect_at(1, "t2_power_show", F_PWR, 990);
        key(4'hF);
        expect_at(1, "t2_clear", F_ADD, 0);
        step(1);

        // on_off abandons an entry of 37
        power_in = 10'd100;
        key(4'd3);
        key(4'd7);
        expect_at(1, "t3_add37", F_ADD, 37);
        on_off = 1'b1;
        expect_at(2, "t3_idle_add", F_ADD, 0);
        expect_at(2, "t3_idle_pwr", F_PWR, 0);
        step(2);
        on_off = 1'b0;
        expect_at(2, "t3_add_dropped", F_ADD, 0);
        expect_at(2, "t3_power_show", F_PWR, 100);
        step(2);

        // Reset during COMMIT aborts it
        key(4'd9);
        key(4'hE);
        rst = 1'b0;
        expect_at(1, "t6_no_load", F_LOAD, 0);
        expect_at(1, "t6_rec_count", F_CNT, 0);
        expect_at(1, "t6_add_show", F_ADD, 0);
        expect_at(1, "t6_power_show", F_PWR, 0);
        expect_at(1, "t6_power_out", F_POUT, 0);
        expect_at(1, "t6_cur_idx", F_IDX, 0);
        step(1);
        rst = 1'b1;
        step(1);

        // Two commits, then query clamp and clear
        power_in = 10'd200;
        commit(4'd1, 201);
        commit(4'd2, 202);
        record_en = 1'b1;
        step(2);
        key(4'd3);
        expect_at(1, "t4_idx_clamp", F_IDX, 1);
        expect_at(1, "t4_rec1_add", F_ADD, 2);
        expect_at(1, "t4_rec1_pwr", F_PWR, 202);
        expect_at(1, "t4_rec_count", F_CNT, 2);
        step(1);
        key(4'hF);
        expect_at(1, "t4_idx_clear", F_IDX, 0);
        expect_at(1, "t4_rec0_add", F_ADD, 1);
        step(1);

        // Three more commits wrap the store; slot 0 holds the newest
        record_en = 1'b0;
        step(1);
        commit(4'd3, 203);
        commit(4'd4, 204);
        commit(4'd5, 205);
        expect_at(1, "t5_count_sat", F_CNT, 4);
        record_en = 1'b1;
        step(2);
        key(4'd2);
        expect_at(1, "t5_idx2", F_IDX, 2);
        expect_at(1, "t5_rec2_add", F_ADD, 3);
        step(1);
        key(4'hA);
        expect_at(1, "t5_reserved", F_IDX, 2);
        step(1);
        key(4'hE);
        expect_at(1, "t5_newest_idx", F_IDX, 0);
        expect_at(1, "t5_newest_add", F_ADD, 5);
        expect_at(1, "t5_newest_pwr", F_PWR, 205);
        step(3);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: got no sample expected %0d", sb[i].name, sb[i].val);
        end
        foreach (load_q[i]) begin
            checks++;
            errors++;
            $display("FAIL missing_load: got no power_load expected power_out=%0d", load_q[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
